// File: rtl/cacheline_plru_update.sv
// Per-set 8-way tree-PLRU state storage with lookup, touch update and flush sweep.
module cacheline_plru_update #(
  parameter int unsigned SET_NUM   = 64,
  parameter int unsigned SET_IDX_W = $clog2(SET_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_vld_i,
  input  logic [SET_IDX_W-1:0] rd_set_i,
  output logic                 rd_state_vld_o,
  output logic [6:0]           rd_state_o,
  input  logic                 touch_vld_i,
  input  logic [SET_IDX_W-1:0] touch_set_i,
  input  logic [2:0]           touch_way_i,
  input  logic                 flush_i,
  output logic                 busy_o
);

  localparam int unsigned NODE_W = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flush_state_e;

  flush_state_e         state_q;
  logic [SET_IDX_W-1:0] cnt_q;
  logic [NODE_W-1:0]    plru_mem [SET_NUM];

  logic [NODE_W-1:0]    touch_cur;
  logic [NODE_W-1:0]    touch_nxt;
  logic                 touch_acc;
  logic                 rd_acc;
  logic                 rd_bypass;

  // Rewrite the tree so every node on the touched way's path points away from it.
  function automatic logic [NODE_W-1:0] plru_touch(input logic [NODE_W-1:0] cur,
                                                   input logic [2:0]        way);
    logic [NODE_W-1:0] nxt;
    nxt    = cur;
    nxt[6] = ~way[2];
    if (way[2]) begin
      nxt[5] = ~way[1];
      if (way[1]) nxt[3] = ~way[0];
      else        nxt[2] = ~way[0];
    end else begin
      nxt[4] = ~way[1];
      if (way[1]) nxt[1] = ~way[0];
      else        nxt[0] = ~way[0];
    end
    return nxt;
  endfunction

  // Accept/bypass decode; a flush request in IDLE wins over a same-cycle touch.
  always_comb begin
    touch_cur = plru_mem[touch_set_i];
    touch_nxt = plru_touch(touch_cur, touch_way_i);
    touch_acc = touch_vld_i & (state_q == IDLE) & ~flush_i;
    rd_acc    = rd_vld_i & (state_q == IDLE);
    rd_bypass = touch_acc & (rd_set_i == touch_set_i);
  end

  // State array, lookup pipeline and flush sweep FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SET_NUM; i++) begin
        plru_mem[i] <= '0;
      end
      state_q        <= IDLE;
      cnt_q          <= '0;
      busy_o         <= 1'b0;
      rd_state_vld_o <= 1'b0;
      rd_state_o     <= '0;
    end else begin
      rd_state_vld_o <= rd_acc;
      if (rd_acc) begin
        rd_state_o <= rd_bypass ? touch_nxt : plru_mem[rd_set_i];
      end
      if (touch_acc) begin
        plru_mem[touch_set_i] <= touch_nxt;
      end
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q <= SWEEP;
            busy_o  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          plru_mem[cnt_q] <= '0;
          if (flush_i) begin
            cnt_q <= '0;
          end else if (cnt_q == SET_IDX_W'(SET_NUM - 1)) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + SET_IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_plru_update.sv
// Self-checking bench for cacheline_plru_update against a range-based tree-PLRU model.
module tb_cacheline_plru_update;

  localparam int unsigned SET_NUM   = 64;
  localparam int unsigned SET_IDX_W = 6;

  logic                 clk;
  logic                 rst_i;
  logic                 rd_vld_i;
  logic [SET_IDX_W-1:0] rd_set_i;
  logic                 rd_state_vld_o;
  logic [6:0]           rd_state_o;
  logic                 touch_vld_i;
  logic [SET_IDX_W-1:0] touch_set_i;
  logic [2:0]           touch_way_i;
  logic                 flush_i;
  logic                 busy_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [6:0] m_mem  [SET_NUM];
  int         m_last [SET_NUM];
  logic       m_busy;
  int         m_pos;
  logic       e_vld;
  logic [6:0] e_rd;

  cacheline_plru_update #(.SET_NUM(SET_NUM), .SET_IDX_W(SET_IDX_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .rd_vld_i       (rd_vld_i),
    .rd_set_i       (rd_set_i),
    .rd_state_vld_o (rd_state_vld_o),
    .rd_state_o     (rd_state_o),
    .touch_vld_i    (touch_vld_i),
    .touch_set_i    (touch_set_i),
    .touch_way_i    (touch_way_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Node bit that governs the way range [lo, lo+size)
  function automatic int node_of(input int lo, input int size);
    if (size == 8) return 6;
    if (size == 4) return (lo == 4) ? 5 : 4;
    return lo / 2;
  endfunction

  // Each node containing the touched way points to the half not containing it.
  function automatic logic [6:0] ref_touch(input logic [6:0] s, input int w);
    logic [6:0] v;
    int lo, size, half;
    v = s; lo = 0; size = 8;
    while (size >= 2) begin
      half = size / 2;
      if (w < lo + half) v[node_of(lo, size)] = 1'b1;
      else begin
        v[node_of(lo, size)] = 1'b0;
        lo = lo + half;
      end
      size = half;
    end
    return v;
  endfunction

  // Follow the pointers from the root down to the victim way.
  function automatic int ref_victim(input logic [6:0] s);
    int lo, size, half;
    lo = 0; size = 8;
    while (size >= 2) begin
      half = size / 2;
      if (s[node_of(lo, size)]) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SET_NUM; i++) begin
      m_mem[i]  = 7'h00;
      m_last[i] = -1;
    end
    m_busy = 1'b0; m_pos = 0; e_vld = 1'b0; e_rd = 7'h00;
  endtask

  task automatic do_reset();
    rd_vld_i = 0; rd_set_i = '0; touch_vld_i = 0; touch_set_i = '0;
    touch_way_i = '0; flush_i = 0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of stimulus and advance the model past the edge.
  task automatic cycle(input logic rv, input logic [5:0] rs, input logic tv,
                       input logic [5:0] ts, input logic [2:0] tw, input logic fl);
    logic [6:0] nt;
    rd_vld_i = rv; rd_set_i = rs; touch_vld_i = tv; touch_set_i = ts;
    touch_way_i = tw; flush_i = fl;
    @(posedge clk);
    #1;
    if (m_busy) begin
      e_vld = 1'b0;
      m_mem[m_pos]  = 7'h00;
      m_last[m_pos] = -1;
      if (fl) m_pos = 0;
      else if (m_pos == SET_NUM - 1) begin m_busy = 1'b0; m_pos = 0; end
      else m_pos++;
    end else begin
      e_vld = rv;
      if (fl) begin
        if (rv) e_rd = m_mem[rs];
        m_busy = 1'b1; m_pos = 0;
      end else begin
        nt = ref_touch(m_mem[ts], int'(tw));
        if (rv) e_rd = (tv && rs == ts) ? nt : m_mem[rs];
        if (tv) begin m_mem[ts] = nt; m_last[ts] = int'(tw); end
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (busy_o !== 1'b0 || rd_state_vld_o !== 1'b0 || rd_state_o !== 7'h00) begin
      bad++; $display("FAIL reset_outputs: busy=%b vld=%b rd=%h required 0/0/00", busy_o, rd_state_vld_o, rd_state_o);
    end
    cycle(1'b1, 6'd3, 1'b0, 6'd0, 3'd0, 1'b0);
    total++;
    if (rd_state_vld_o !== 1'b1 || rd_state_o !== 7'h00) begin
      bad++; $display("FAIL reset_lookup: vld=%b rd=%h required 1/00", rd_state_vld_o, rd_state_o);
    end
  endtask

  task automatic test_touch_seq();
    logic [6:0] req [3];
    logic [2:0] way [3];
    req[0] = 7'h51; req[1] = 7'h31; req[2] = 7'h11;
    way[0] = 3'd0;  way[1] = 3'd5;  way[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'd0, 1'b1, 6'd5, way[i], 1'b0);
      cycle(1'b1, 6'd5, 1'b0, 6'd0, 3'd0, 1'b0);
      total++;
      if (rd_state_vld_o !== 1'b1 || rd_state_o !== req[i] || rd_state_o !== e_rd) begin
        bad++; $display("FAIL touch_seq[%0d]: vld=%b rd=%h required 1/%h", i, rd_state_vld_o, rd_state_o, req[i]);
      end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    cycle(1'b1, 6'd2, 1'b1, 6'd2, 3'd3, 1'b0);
    total++;
    if (rd_state_vld_o !== 1'b1 || rd_state_o !== 7'h40) begin
      bad++; $display("FAIL bypass_same_set: vld=%b rd=%h required 1/40", rd_state_vld_o, rd_state_o);
    end
    do_reset();
    cycle(1'b1, 6'd9, 1'b1, 6'd2, 3'd3, 1'b0);
    total++;
    if (rd_state_vld_o !== 1'b1 || rd_state_o !== 7'h00) begin
      bad++; $display("FAIL bypass_other_set: vld=%b rd=%h required 1/00", rd_state_vld_o, rd_state_o);
    end
    cycle(1'b1, 6'd2, 1'b0, 6'd0, 3'd0, 1'b0);
    total++;
    if (rd_state_o !== 7'h40) begin
      bad++; $display("FAIL touch_written: rd=%h required 40", rd_state_o);
    end
  endtask

  task automatic test_flush();
    int n;
    logic [5:0] sets [3];
    sets[0] = 6'd0; sets[1] = 6'd31; sets[2] = 6'd63;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'd0, 1'b1, sets[i], 3'(i + 1), 1'b0);
    cycle(1'b1, 6'd63, 1'b0, 6'd0, 3'd0, 1'b0);
    total++;
    if (rd_state_o === 7'h00 || rd_state_o !== e_rd) begin
      bad++; $display("FAIL pre_flush_state: rd=%h required %h", rd_state_o, e_rd);
    end
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 3'd0, 1'b1);
    n = busy_o ? 1 : 0;
    for (int k = 0; k < 200 && busy_o === 1'b1; k++) begin
      cycle(1'b1, 6'd31, 1'b1, 6'd31, 3'd4, 1'b0);
      total++;
      if (rd_state_vld_o !== 1'b0) begin
        bad++; $display("FAIL busy_lookup_dropped: vld=%b required 0", rd_state_vld_o);
      end
      if (busy_o === 1'b1) n++;
    end
    total++;
    if (n != 64) begin
      bad++; $display("FAIL flush_busy_len: cycles=%0d required 64", n);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, sets[i], 1'b0, 6'd0, 3'd0, 1'b0);
      total++;
      if (rd_state_vld_o !== 1'b1 || rd_state_o !== 7'h00) begin
        bad++; $display("FAIL post_flush[%0d]: vld=%b rd=%h required 1/00", sets[i], rd_state_vld_o, rd_state_o);
      end
    end
  endtask

  task automatic test_reflush_and_reset();
    int n;
    do_reset();
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 3'd0, 1'b1);
    repeat (9) idle();
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 3'd0, 1'b1);
    n = busy_o ? 1 : 0;
    for (int k = 0; k < 200 && busy_o === 1'b1; k++) begin
      idle();
      if (busy_o === 1'b1) n++;
    end
    total++;
    if (n != 64) begin
      bad++; $display("FAIL reflush_busy_len: cycles=%0d required 64", n);
    end
    cycle(1'b0, 6'd0, 1'b1, 6'd12, 3'd6, 1'b0);
    cycle(1'b1, 6'd12, 1'b0, 6'd0, 3'd0, 1'b1);
    repeat (5) idle();
    rst_i = 1'b1;
    #2;
    total++;
    if (busy_o !== 1'b0 || rd_state_vld_o !== 1'b0 || rd_state_o !== 7'h00) begin
      bad++; $display("FAIL midsweep_reset: busy=%b vld=%b rd=%h required 0/0/00", busy_o, rd_state_vld_o, rd_state_o);
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
    cycle(1'b1, 6'd40, 1'b0, 6'd0, 3'd0, 1'b0);
    total++;
    if (busy_o !== 1'b0 || rd_state_vld_o !== 1'b1 || rd_state_o !== 7'h00) begin
      bad++; $display("FAIL after_reset_lookup: busy=%b vld=%b rd=%h required 0/1/00", busy_o, rd_state_vld_o, rd_state_o);
    end
  endtask

  task automatic test_random();
    logic       rv, tv, fl;
    logic [5:0] rs, ts;
    logic [2:0] tw;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rv = 1'($urandom_range(0, 3) != 0);
      tv = 1'($urandom_range(0, 2) != 0);
      fl = 1'($urandom_range(0, 299) == 0);
      rs = 6'($urandom_range(0, 7));
      ts = ($urandom_range(0, 1) == 0) ? rs : 6'($urandom_range(0, 7));
      tw = 3'($urandom_range(0, 7));
      cycle(rv, rs, tv, ts, tw, fl);
      total++;
      if (busy_o !== m_busy || rd_state_vld_o !== e_vld || rd_state_o !== e_rd) begin
        bad++; $display("FAIL random[%0d]: busy=%b vld=%b rd=%h required %b/%b/%h", k, busy_o, rd_state_vld_o, rd_state_o, m_busy, e_vld, e_rd);
      end
      if (e_vld && m_last[rs] >= 0) begin
        total++;
        if (ref_victim(rd_state_o) == m_last[rs]) begin
          bad++; $display("FAIL random_victim[%0d]: victim=%0d required not %0d", k, ref_victim(rd_state_o), m_last[rs]);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    model_reset();
    test_reset();
    test_touch_seq();
    test_bypass();
    test_flush();
    test_reflush_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
